// File: rtl/instr_rom_loader_pkg.sv
// Purpose: shared constants and types for the 8-bit core's fetch/loader path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int INSTR_W = 8;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_LW  = 2'd1;
  localparam logic [1:0] OP_SW  = 2'd2;
  localparam logic [1:0] OP_J   = 2'd3;

  // j +0: the core spins in place whenever no valid program word exists
  localparam logic [INSTR_W-1:0] STALL_WORD = {OP_J, 6'd0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } ld_state_t;

endpackage

// File: rtl/instr_rom_loader_prog_ram.sv
// Purpose: DEPTH x INSTR_W program storage, cleared to the stall word on reset.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none; the caller qualifies writes.
module prog_ram
  import cpu_pkg::*;
#(
  parameter int                 DEPTH   = 16,
  parameter int                 ADDR_W  = 4,
  parameter logic [INSTR_W-1:0] STALL_W = STALL_WORD
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Storage: every word returns to the stall word on reset, otherwise write when enabled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= STALL_W;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_rom_loader.sv
// Purpose: loads a program over a byte stream, then serves instructions to the core at pc.
// Latency: instruction is combinational from pc; cpu_reset drops 2 cycles after the last byte.
// Backpressure: load_ready is high only in LOAD; bytes offered elsewhere are dropped.
module instr_rom_loader
  import cpu_pkg::*;
#(
  parameter int                 DEPTH   = 16,
  parameter int                 ADDR_W  = 4,
  parameter logic [INSTR_W-1:0] STALL_W = STALL_WORD
) (
  input  logic               origclk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_err,
  output logic               cpu_reset,
  input  logic [7:0]         pc,
  output logic [INSTR_W-1:0] instruction
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W+1)'(DEPTH);

  ld_state_t           r_state;
  ld_state_t           w_state_nxt;
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W:0]     r_prog_len;
  logic                r_load_err;

  logic                w_load_ready;
  logic                w_cpu_reset;
  logic                w_enter_load;
  logic                w_accept;
  logic                w_at_end;
  logic [INSTR_W-1:0]  w_rdata;
  logic [8:0]          w_pc_ext;
  logic [8:0]          w_len_ext;
  logic                w_pc_valid;

  assign w_accept = load_valid & w_load_ready;
  assign w_at_end = (r_wptr == LAST_ADDR);

  // State register
  always_ff @(posedge origclk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; core stays in reset everywhere except RUN
  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = 1'b0;
    w_cpu_reset  = 1'b1;
    w_enter_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_start) begin
          w_state_nxt  = LOAD;
          w_enter_load = 1'b1;
        end
      end
      LOAD: begin
        w_load_ready = 1'b1;
        if (load_valid && (load_last || w_at_end)) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        w_cpu_reset = 1'b0;
        if (load_start) begin
          w_state_nxt  = LOAD;
          w_enter_load = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Write pointer, program length and sticky overflow flag
  always_ff @(posedge origclk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_prog_len <= '0;
      r_load_err <= 1'b0;
    end else if (w_enter_load) begin
      r_wptr     <= '0;
      r_prog_len <= '0;
      r_load_err <= 1'b0;
    end else if (w_accept) begin
      r_wptr <= r_wptr + ADDR_W'(1);
      if (load_last) begin
        r_prog_len <= (ADDR_W+1)'(r_wptr) + (ADDR_W+1)'(1);
      end else if (w_at_end) begin
        r_prog_len <= FULL_LEN;
        r_load_err <= 1'b1;
      end
    end
  end

  prog_ram #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .STALL_W (STALL_W)
  ) u_prog_ram (
    .i_clk   (origclk),
    .i_rst   (reset),
    .i_we    (w_accept),
    .i_waddr (r_wptr),
    .i_wdata (load_data),
    .i_raddr (pc[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  // Full-width pc compare so addresses at or beyond DEPTH never alias low words
  assign w_pc_ext   = {1'b0, pc};
  assign w_len_ext  = 9'(r_prog_len);
  assign w_pc_valid = (r_state == RUN) && (w_pc_ext < w_len_ext);

  assign instruction = w_pc_valid ? w_rdata : STALL_W;
  assign load_ready  = w_load_ready;
  assign cpu_reset   = w_cpu_reset;
  assign load_err    = r_load_err;

endmodule

// File: tb/tb_instr_rom_loader.sv
// Purpose: directed self-checking bench for instr_rom_loader with a byte scoreboard.
// Latency: checks sample 1-2 time units after the rising edge.
// Backpressure: exercises gaps in load_valid and bytes offered while not ready.
module tb_instr_rom_loader;

  logic       origclk = 1'b0;
  logic       reset   = 1'b1;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data  = 8'h00;
  logic       load_last  = 1'b0;
  logic       load_ready;
  logic       load_err;
  logic       cpu_reset;
  logic [7:0] pc = 8'h00;
  logic [7:0] instruction;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  localparam logic [7:0] STALL = 8'hC0;

  instr_rom_loader dut (
    .origclk     (origclk),
    .reset       (reset),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_err    (load_err),
    .cpu_reset   (cpu_reset),
    .pc          (pc),
    .instruction (instruction)
  );

  always #5 origclk = ~origclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge origclk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    exp_q.push_back(d);
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 8'hEE;
  endtask

  task automatic gap();
    load_valid = 1'b0;
    load_data  = 8'hEE;
    step();
  endtask

  // Pop every queued byte against pc=0.., then expect the stall word just past the program
  task automatic drain(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      pc = 8'(i);
      #1;
      chk(tag, instruction, exp_q.pop_front());
      i++;
    end
    pc = 8'(i);
    #1;
    chk({tag, "_past_end"}, instruction, STALL);
  endtask

  initial begin
    // Reset then idle
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("rst_cpu_reset", 8'(cpu_reset), 8'd1);
    chk("rst_load_ready", 8'(load_ready), 8'd0);
    chk("rst_load_err", 8'(load_err), 8'd0);
    for (int i = 0; i < 256; i++) begin
      pc = 8'(i);
      #1;
      chk("idle_stall", instruction, STALL);
    end

    // Three bytes back-to-back
    start_load();
    chk("load_ready_in_load", 8'(load_ready), 8'd1);
    chk("load_cpu_reset", 8'(cpu_reset), 8'd1);
    pc = 8'd0;
    send_byte(8'h71, 1'b0);
    #1;
    chk("load_read_stall", instruction, STALL);
    send_byte(8'h05, 1'b0);
    send_byte(8'hC2, 1'b1);
    chk("flush_cpu_reset", 8'(cpu_reset), 8'd1);
    chk("flush_load_ready", 8'(load_ready), 8'd0);
    step();
    chk("run_cpu_reset", 8'(cpu_reset), 8'd0);
    chk("run_load_ready", 8'(load_ready), 8'd0);
    drain("prog3");

    // Stalled load: valid 1,0,1,0 with two bytes
    start_load();
    send_byte(8'hA1, 1'b0);
    gap();
    send_byte(8'hB2, 1'b1);
    chk("stall_flush_cpu_reset", 8'(cpu_reset), 8'd1);
    gap();
    chk("stall_run_cpu_reset", 8'(cpu_reset), 8'd0);
    drain("prog2");

    // Overflow: 16 bytes, no last
    start_load();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b0);
    end
    chk("ovf_load_err", 8'(load_err), 8'd1);
    chk("ovf_flush_cpu_reset", 8'(cpu_reset), 8'd1);
    load_valid = 1'b1;
    load_data  = 8'h55;
    #1;
    chk("ovf_17th_not_ready", 8'(load_ready), 8'd0);
    step();
    load_valid = 1'b0;
    chk("ovf_run_cpu_reset", 8'(cpu_reset), 8'd0);
    chk("ovf_err_sticky", 8'(load_err), 8'd1);
    drain("prog16");
    pc = 8'd255;
    #1;
    chk("ovf_pc255", instruction, STALL);

    // Reload from RUN with a single byte
    start_load();
    chk("reload_cpu_reset", 8'(cpu_reset), 8'd1);
    chk("reload_err_clear", 8'(load_err), 8'd0);
    send_byte(8'h40, 1'b1);
    step();
    chk("reload_run", 8'(cpu_reset), 8'd0);
    drain("prog1");

    // Reset in the middle of a four-byte load
    start_load();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    exp_q.delete();
    reset = 1'b1;
    #1;
    chk("midrst_cpu_reset", 8'(cpu_reset), 8'd1);
    chk("midrst_load_ready", 8'(load_ready), 8'd0);
    chk("midrst_load_err", 8'(load_err), 8'd0);
    for (int i = 0; i < 256; i++) begin
      pc = 8'(i);
      #1;
      chk("midrst_stall", instruction, STALL);
    end
    step();
    reset = 1'b0;
    step();

    // load_start together with load_valid in IDLE: byte must not be written
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h99;
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
    send_byte(8'h3C, 1'b1);
    step();
    chk("idle_start_valid_run", 8'(cpu_reset), 8'd0);
    drain("prog_sv");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
